// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns field-level requests into 32-bit instruction words,
// flags malformed requests, and buffers results in a 2-entry in-order FIFO.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  f3,
  input  logic [6:0]  f7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [15:0] count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [32:0] slot_reg [2];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  occ_reg;
  logic [15:0] count_reg;

  logic        push;
  logic        pop;
  logic        is_shift;
  logic        illegal;
  logic [31:0] instr_next;
  logic        err_next;

  // Occupancy is registered, so a pop in the same cycle never reopens a full FIFO.
  assign in_ready  = (occ_reg != 2'd2);
  assign out_valid = (occ_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign instr     = slot_reg[rd_ptr_reg][31:0];
  assign err       = slot_reg[rd_ptr_reg][32];
  assign count     = count_reg;

  always_comb begin
    is_shift   = (fmt == 3'd1) && (opcode == 7'b0010011) && ((f3 == 3'b001) || (f3 == 3'b101));
    illegal    = (fmt > 3'd5) || (opcode[1:0] != 2'b11);
    instr_next = NOP;
    err_next   = 1'b0;
    case (fmt)
      3'd0: instr_next = {f7, rs2, rs1, f3, rd, opcode};
      3'd1: begin
        instr_next = {(is_shift ? f7 : imm[11:5]), imm[4:0], rs1, f3, rd, opcode};
        err_next   = is_shift && (imm[11:5] != 7'd0);
      end
      3'd2: instr_next = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
      3'd3: begin
        instr_next = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
        err_next   = imm[0];
      end
      3'd4: instr_next = {imm[31:12], rd, opcode};
      3'd5: begin
        instr_next = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err_next   = imm[0];
      end
      default: instr_next = NOP;
    endcase
    if (illegal) begin
      instr_next = NOP;
      err_next   = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          slot_reg[gi] <= 33'd0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          slot_reg[gi] <= {err_next, instr_next};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
      count_reg  <= 16'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
      if (push && (count_reg != 16'hFFFF)) count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: known-answer table, scripted back-pressure/reset
// sequences, random traffic against an arithmetic encoding model, and count saturation.
module tb_instr_encoder;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    string       name;
    req_t        r;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [2:0]  fmt = 0;
  logic [6:0]  opcode = 0;
  logic [2:0]  f3 = 0;
  logic [6:0]  f7 = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] instr;
  logic        err;
  logic [15:0] count;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .f3(f3), .f7(f7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  bit          verbose = 1;
  logic [32:0] exp_q[$];
  int          exp_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from bit positions with shifts and masks.
  function automatic logic [32:0] ref_encode(input req_t r);
    int unsigned op, w, im, hi;
    bit          e;
    op = r.opcode; im = r.imm; e = 0; w = 0;
    if (r.fmt > 5 || (op & 3) != 3) return {1'b1, 32'h13};
    case (r.fmt)
      0: w = (r.f7 << 25) | (r.rs2 << 20) | (r.rs1 << 15) | (r.f3 << 12) | (r.rd << 7) | op;
      1: begin
        bit sh = (op == 'h13) && (r.f3 == 1 || r.f3 == 5);
        hi = sh ? r.f7 : ((im >> 5) & 'h7F);
        e  = sh && (((im >> 5) & 'h7F) != 0);
        w  = (hi << 25) | ((im & 31) << 20) | (r.rs1 << 15) | (r.f3 << 12) | (r.rd << 7) | op;
      end
      2: w = (((im >> 5) & 'h7F) << 25) | (r.rs2 << 20) | (r.rs1 << 15) | (r.f3 << 12)
             | ((im & 31) << 7) | op;
      3: begin
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (r.rs2 << 20) | (r.rs1 << 15)
            | (r.f3 << 12) | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | op;
        e = im[0];
      end
      4: w = (im & 'hFFFFF000) | (r.rd << 7) | op;
      default: begin
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 'h3FF) << 21) | (((im >> 11) & 1) << 20)
            | (((im >> 12) & 'hFF) << 12) | (r.rd << 7) | op;
        e = im[0];
      end
    endcase
    return {e, w};
  endfunction

  function automatic req_t rand_req(input bit legal);
    req_t r;
    r = req_t'({$urandom, $urandom});
    r.fmt = legal ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
    if (legal || $urandom_range(0, 3) != 0) r.opcode[1:0] = 2'b11;
    if ($urandom_range(0, 4) == 0) begin
      r.opcode = 7'b0010011;
      r.f3 = $urandom_range(0, 1) ? 3'b001 : 3'b101;
      if ($urandom_range(0, 1) != 0) r.imm[11:5] = 7'd0;
    end
    if ($urandom_range(0, 1) != 0) r.imm[0] = 1'b0;
    return r;
  endfunction

  // One clock cycle, entered and left at a falling edge: check state, drive, advance model.
  task automatic cycle(input bit iv, input bit ordy, input req_t r, input logic [32:0] exp);
    bit do_push, do_pop;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    chk("count", 32'(count), 32'(exp_count));
    if (exp_q.size() > 0) begin
      chk("instr", instr, exp_q[0][31:0]);
      chk("err", 32'(err), 32'(exp_q[0][32]));
    end
    in_valid = iv; out_ready = ordy;
    fmt = r.fmt; opcode = r.opcode; f3 = r.f3; f7 = r.f7;
    rd = r.rd; rs1 = r.rs1; rs2 = r.rs2; imm = r.imm;
    do_push = iv && exp_q.size() < 2;
    do_pop  = ordy && exp_q.size() > 0;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      exp_q.push_back(exp);
      if (exp_count < 'hFFFF) exp_count++;
      if (verbose)
        $display("accept fmt=%0d op=%07b imm=0x%08h -> instr=0x%08h err=%0b",
                 r.fmt, r.opcode, r.imm, exp[31:0], exp[32]);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 1; out_ready = 1;
    @(posedge clk); @(negedge clk);
    rst_n = 1; in_valid = 0; out_ready = 0;
    exp_q.delete(); exp_count = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
  endtask

  function automatic req_t mk(input logic [2:0] f, input logic [6:0] op, input logic [2:0] fn3,
                              input logic [6:0] fn7, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] im);
    return '{fmt: f, opcode: op, f3: fn3, f7: fn7, rd: d, rs1: s1, rs2: s2, imm: im};
  endfunction

  initial begin
    vec_t  vecs[$];
    req_t  r, ra, rb, rc;
    req_t  idle;
    logic [32:0] e;

    idle = '0;
    vecs.push_back('{"r_add",   mk(0, 7'b0110011, 0, 0, 3, 1, 2, 0),            32'h002081B3, 0});
    vecs.push_back('{"i_addi",  mk(1, 7'b0010011, 0, 0, 1, 0, 0, 32'hFFFFFFFF), 32'hFFF00093, 0});
    vecs.push_back('{"u_lui",   mk(4, 7'b0110111, 0, 0, 5, 0, 0, 32'h12345000), 32'h123452B7, 0});
    vecs.push_back('{"b_beq8",  mk(3, 7'b1100011, 0, 0, 0, 1, 2, 8),            32'h00208463, 0});
    vecs.push_back('{"b_beq9",  mk(3, 7'b1100011, 0, 0, 0, 1, 2, 9),            32'h00208463, 1});
    vecs.push_back('{"fmt7",    mk(7, 7'b0110011, 0, 0, 3, 1, 2, 0),            32'h00000013, 1});
    vecs.push_back('{"bad_op",  mk(0, 7'b0110010, 0, 0, 3, 1, 2, 0),            32'h00000013, 1});
    vecs.push_back('{"srai",    mk(1, 7'b0010011, 5, 7'h20, 1, 2, 0, 3),        32'h40315093, 0});
    vecs.push_back('{"slli_bad",mk(1, 7'b0010011, 1, 0, 1, 2, 0, 32'h23),       32'h00311093, 1});
    vecs.push_back('{"s_sw",    mk(2, 7'b0100011, 2, 0, 0, 2, 3, 32'hFFFFFFFC), 32'hFE312E23, 0});
    vecs.push_back('{"j_jal",   mk(5, 7'b1101111, 0, 0, 1, 0, 0, 32'h00000800), 32'h001000EF, 0});
    vecs.push_back('{"j_odd",   mk(5, 7'b1101111, 0, 0, 1, 0, 0, 32'h00000801), 32'h001000EF, 1});

    repeat (3) @(negedge clk);
    do_reset();

    foreach (vecs[i]) begin
      cycle(1, 1, vecs[i].r, {vecs[i].err, vecs[i].instr});
      cycle(0, 1, idle, '0);
    end

    // Back-pressure: three back-to-back requests with the consumer stalled.
    ra = mk(0, 7'b0110011, 0, 0, 3, 1, 2, 0);
    rb = mk(4, 7'b0110111, 0, 0, 5, 0, 0, 32'h12345000);
    rc = mk(3, 7'b1100011, 0, 0, 0, 1, 2, 8);
    cycle(1, 0, ra, ref_encode(ra));
    cycle(1, 0, rb, ref_encode(rb));
    cycle(1, 0, rc, ref_encode(rc));
    chk("bp_full_in_ready", 32'(in_ready), 0);
    cycle(1, 1, rc, ref_encode(rc));
    cycle(1, 1, rc, ref_encode(rc));
    cycle(0, 1, idle, '0);
    cycle(0, 1, idle, '0);
    cycle(0, 0, idle, '0);

    // Reset with two entries queued and a push/pop attempted in that cycle.
    cycle(1, 0, ra, ref_encode(ra));
    cycle(1, 0, rb, ref_encode(rb));
    chk("pre_rst_full", 32'(in_ready), 0);
    do_reset();
    cycle(0, 0, idle, '0);

    // Random traffic with random back-pressure and gaps.
    for (int n = 0; n < 400; n++) begin
      r = rand_req(0);
      e = ref_encode(r);
      cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), r, e);
    end
    do_reset();

    // Saturation: a continuous stream longer than the counter range.
    verbose = 0;
    for (int n = 0; n < 65540; n++) begin
      r = rand_req(1);
      cycle(1, 1, r, ref_encode(r));
    end
    verbose = 1;
    cycle(0, 1, idle, '0);
    chk("count_sat", 32'(count), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 in_valid  input  1  request carries valid fields this cycle.
REQ-005 in_ready  output  1  block accepts the request this cycle.
REQ-006 fmt  input  3  format select: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-007 opcode  input  7  opcode field, placed in instruction bits 6:0.
REQ-008 f3  input  3  funct3 field.
REQ-009 f7  input  7  funct7 field.
REQ-010 rd, rs1, rs2  input  5 each  register indices.
REQ-011 imm  input  32  immediate, byte-offset units for B and J formats.
REQ-012 out_valid  output  1  instr and err are valid.
REQ-013 out_ready  input  1  consumer takes the output this cycle.
REQ-014 instr  output  32  encoded RV32I instruction word.
REQ-015 err  output  1  the request held in the output slot was malformed.
REQ-016 count  output  16  number of accepted requests, saturating.

Function
REQ-017 A request is accepted on a rising edge when in_valid=1 and in_ready=1.
REQ-018 An output is consumed on a rising edge when out_valid=1 and out_ready=1.
REQ-019 The block SHALL hold accepted results in a 2-entry FIFO and present them in order.
REQ-020 in_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries.
  - in_ready SHALL be 0 when the FIFO is full, even when a pop occurs in the same cycle.
REQ-021 Latency SHALL be 1 cycle.
  - Accept at edge N into an empty FIFO -> out_valid=1 with that result after edge N.
REQ-022 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
  - FIFO order SHALL be preserved.
REQ-023 While out_valid=1 and out_ready=0, instr and err SHALL hold stable.
REQ-024 R format: instr = {f7, rs2, rs1, f3, rd, opcode}.
REQ-025 I format: instr = {imm[11:0], rs1, f3, rd, opcode}.
  - When opcode=0010011 and f3 is 001 or 101, bits 31:25 SHALL be f7 instead of imm[11:5].
REQ-026 S format: instr = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode}.
REQ-027 B format: instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode}.
REQ-028 U format: instr = {imm[31:12], rd, opcode}.
REQ-029 J format: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-030 Immediate bits not listed for a format SHALL be ignored without error, except imm[0] in B and J formats.
REQ-031 err SHALL be 1 when fmt is 6 or 7, or opcode[1:0] != 2'b11.
  - In this case instr SHALL be 32'h00000013 (NOP).
REQ-032 err SHALL be 1 when fmt is B or J and imm[0]=1.
  - The instruction SHALL still be encoded as specified, with bit 0 dropped.
REQ-033 err SHALL be 1 when fmt is I with a shift opcode/f3 and imm[11:5] != 0.
  - Encoding SHALL follow REQ-025.
REQ-034 count SHALL increment by 1 on every accept and SHALL saturate at 16'hFFFF.
REQ-035 Inputs SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-036 While rst_n=0 at a rising edge, the block SHALL reset as follows:
  - FIFO emptied.
  - out_valid=0, instr=0, err=0, count=0.
  - in_ready=1 from the first cycle after the reset edge.
REQ-037 A reset asserted while the FIFO is full or being consumed SHALL discard all entries.
  - The accept/pop in that cycle SHALL be ignored.

Verification
REQ-038 R-type add: fmt=0, op=0110011, f3=0, f7=0, rd=3, rs1=1, rs2=2 -> instr=0x002081B3, err=0, one cycle later.
REQ-039 I-type and U-type:
  - fmt=1, op=0010011, rd=1, rs1=0, imm=0xFFFFFFFF -> 0xFFF00093.
  - fmt=4, op=0110111, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-040 B-type beq: op=1100011, rs1=1, rs2=2, imm=8 -> 0x00208463, err=0.
  - Same request with imm=9 -> 0x00208463, err=1.
REQ-041 Back-pressure: hold out_ready=0 and present 3 back-to-back requests.
  - The first two are accepted; in_ready=0 on the third.
  - Raise out_ready -> outputs emerge in order; the third is accepted only after occupancy <2.
REQ-042 Illegal: fmt=7 -> instr=0x00000013, err=1.
  - Reset with 2 queued entries -> out_valid=0, count=0 on the next cycle.
  - count saturates at 0xFFFF after 65536+ accepts.
